// File: rtl/frame_color_classifier.sv
// Per-frame red/blue pixel classifier for the RGB332 VGA read stream; publishes the dominant colour in RESULT.
// Define SHAPE_DETECT_EN to add per-band counters and a coarse shape code in RESULT[3:2].
module frame_color_classifier #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int RED_R_MIN     = 5,
    parameter int BLUE_B_MIN    = 2,
    parameter int MIN_PIXELS    = 400
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [8:0] RESULT,
    output logic       FRAME_DONE
);
    localparam logic [9:0]  WIDTH    = 10'(SCREEN_WIDTH);
    localparam logic [9:0]  HEIGHT   = 10'(SCREEN_HEIGHT);
    localparam logic [2:0]  R_MIN    = 3'(RED_R_MIN);
    localparam logic [1:0]  B_MIN    = 2'(BLUE_B_MIN);
    localparam logic [14:0] MIN_CNT  = 15'(MIN_PIXELS);
    localparam logic [14:0] CNT_MAX  = 15'h7FFF;

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

    state_t      state;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic        vsync_d;
    logic [14:0] red_cnt;
    logic [14:0] blue_cnt;

    logic        boundary;
    logic        active;
    logic        is_red;
    logic        is_blue;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic [1:0]  colour;
    logic [1:0]  shape;

    assign r = PIXEL_IN[7:5];
    assign g = PIXEL_IN[4:2];
    assign b = PIXEL_IN[1:0];

    // RAM data lags its address by a cycle, so the registered coordinates belong to PIXEL_IN.
    assign boundary = vsync_d & ~VGA_VSYNC_NEG;
    assign active   = (x_d < WIDTH) && (y_d < HEIGHT);
    assign is_red   = (r >= R_MIN) && (g <= 3'd2) && (b <= 2'd1);
    assign is_blue  = !is_red && (b >= B_MIN) && (r <= 3'd2) && (g <= 3'd3);

    always_comb begin
        colour = 2'b00;
        if (red_cnt >= MIN_CNT && red_cnt > blue_cnt)
            colour = 2'b01;
        else if (blue_cnt >= MIN_CNT && blue_cnt > red_cnt)
            colour = 2'b10;
    end

`ifdef SHAPE_DETECT_EN
    localparam logic [9:0] BAND1 = 10'(SCREEN_HEIGHT / 3);
    localparam logic [9:0] BAND2 = 10'((2 * SCREEN_HEIGHT) / 3);

    logic [2:0][14:0] red_band;
    logic [2:0][14:0] blue_band;
    logic [1:0]       band;
    logic [16:0]      top;
    logic [16:0]      mid;
    logic [16:0]      bot;
    logic [16:0]      diff_tm;
    logic [16:0]      diff_bm;

    always_comb begin
        band = 2'd2;
        if (y_d < BAND1)
            band = 2'd0;
        else if (y_d < BAND2)
            band = 2'd1;
    end

    always_comb begin
        top   = '0;
        mid   = '0;
        bot   = '0;
        shape = 2'b00;
        if (colour == 2'b01) begin
            top = {2'b00, red_band[0]};
            mid = {2'b00, red_band[1]};
            bot = {2'b00, red_band[2]};
        end else if (colour == 2'b10) begin
            top = {2'b00, blue_band[0]};
            mid = {2'b00, blue_band[1]};
            bot = {2'b00, blue_band[2]};
        end
        diff_tm = (top > mid) ? top - mid : mid - top;
        diff_bm = (bot > mid) ? bot - mid : mid - bot;
        if (colour != 2'b00) begin
            if ((diff_tm << 2) <= mid && (diff_bm << 2) <= mid)
                shape = 2'b01;
            else if ((top << 1) < mid && mid <= bot)
                shape = 2'b10;
            else if ((top << 1) < mid && (bot << 1) < mid)
                shape = 2'b11;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            red_band  <= '0;
            blue_band <= '0;
        end else if ((state == IDLE && boundary) || state == DECIDE) begin
            red_band  <= '0;
            blue_band <= '0;
        end else if (state == ACCUM && !boundary && active) begin
            if (is_red && red_band[band] != CNT_MAX)
                red_band[band] <= red_band[band] + 15'd1;
            if (is_blue && blue_band[band] != CNT_MAX)
                blue_band[band] <= blue_band[band] + 15'd1;
        end
    end
`else
    assign shape = 2'b00;
`endif

    // The decision is taken from the finished counts on the boundary edge; DECIDE then clears them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            x_d        <= '0;
            y_d        <= '0;
            vsync_d    <= 1'b1;
            red_cnt    <= '0;
            blue_cnt   <= '0;
            RESULT     <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            x_d        <= VGA_PIXEL_X;
            y_d        <= VGA_PIXEL_Y;
            vsync_d    <= VGA_VSYNC_NEG;
            FRAME_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (boundary) begin
                        state    <= ACCUM;
                        red_cnt  <= '0;
                        blue_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (boundary) begin
                        state      <= DECIDE;
                        RESULT     <= {1'b1, 4'b0000, shape, colour};
                        FRAME_DONE <= 1'b1;
                    end else if (active) begin
                        if (is_red && red_cnt != CNT_MAX)
                            red_cnt <= red_cnt + 15'd1;
                        if (is_blue && blue_cnt != CNT_MAX)
                            blue_cnt <= blue_cnt + 15'd1;
                    end
                end
                DECIDE: begin
                    state    <= ACCUM;
                    red_cnt  <= '0;
                    blue_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_color_classifier.sv
// Self-checking bench for frame_color_classifier: directed and randomized frames against a counting model.
// Shape checks are compiled only when SHAPE_DETECT_EN is defined.
module tb_frame_color_classifier;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pixel_in;
    logic [9:0] vga_x;
    logic [9:0] vga_y;
    logic       vsync_neg;
    logic [8:0] result;
    logic       frame_done;

    int assert_count = 0;
    int fail_count   = 0;

    logic [7:0] pending_pix;
    int         model_red;
    int         model_blue;
    int         model_band_red[3];
    int         model_band_blue[3];
    bit         model_armed;
    logic [8:0] model_result;

    always #20 clk = ~clk;

    frame_color_classifier dut (
        .CLK          (clk),
        .RESET        (reset),
        .PIXEL_IN     (pixel_in),
        .VGA_PIXEL_X  (vga_x),
        .VGA_PIXEL_Y  (vga_y),
        .VGA_VSYNC_NEG(vsync_neg),
        .RESULT       (result),
        .FRAME_DONE   (frame_done)
    );

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // 0 = neither, 1 = red, 2 = blue; red wins when both rules hold.
    function automatic int classify(input logic [7:0] p);
        int r;
        int g;
        int b;
        r = int'(p[7:5]);
        g = int'(p[4:2]);
        b = int'(p[1:0]);
        if (r >= 5 && g <= 2 && b <= 1) return 1;
        if (b >= 2 && r <= 2 && g <= 3) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] model_shape(input int t, input int m, input int b);
        int dt;
        int db;
        dt = (t > m) ? t - m : m - t;
        db = (b > m) ? b - m : m - b;
        if (4 * dt <= m && 4 * db <= m) return 2'b01;
        if (2 * t < m && m <= b) return 2'b10;
        if (2 * t < m && 2 * b < m) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [8:0] model_decision();
        logic [1:0] colour;
        logic [1:0] shape;
        colour = 2'b00;
        shape  = 2'b00;
        if (model_red >= 400 && model_red > model_blue) colour = 2'b01;
        else if (model_blue >= 400 && model_blue > model_red) colour = 2'b10;
`ifdef SHAPE_DETECT_EN
        if (colour == 2'b01)
            shape = model_shape(model_band_red[0], model_band_red[1], model_band_red[2]);
        else if (colour == 2'b10)
            shape = model_shape(model_band_blue[0], model_band_blue[1], model_band_blue[2]);
`endif
        return {1'b1, 4'b0000, shape, colour};
    endfunction

    task automatic model_clear();
        model_red  = 0;
        model_blue = 0;
        for (int i = 0; i < 3; i++) begin
            model_band_red[i]  = 0;
            model_band_blue[i] = 0;
        end
    endtask

    // Present one pixel the way the RAM does: coordinates now, their data one cycle later.
    task automatic apply_stimulus(input int px, input int py, input logic [7:0] pix);
        int c;
        int band;
        vga_x       = 10'(px);
        vga_y       = 10'(py);
        pixel_in    = pending_pix;
        pending_pix = pix;
        @(posedge clk);
        #1;
        if (model_armed && px < 176 && py < 144) begin
            c    = classify(pix);
            band = (py * 3) / 144;
            if (c == 1) begin
                if (model_red < 32767) model_red++;
                if (model_band_red[band] < 32767) model_band_red[band]++;
            end else if (c == 2) begin
                if (model_blue < 32767) model_blue++;
                if (model_band_blue[band] < 32767) model_band_blue[band]++;
            end
        end
    endtask

    task automatic frame_boundary(input string tag);
        logic exp_done;
        apply_stimulus(700, 700, 8'h00);
        if (model_armed) begin
            model_result = model_decision();
            exp_done     = 1'b1;
        end else begin
            model_armed = 1'b1;
            exp_done    = 1'b0;
        end
        model_clear();
        vsync_neg   = 1'b0;
        pixel_in    = pending_pix;
        pending_pix = 8'h00;
        @(posedge clk);
        #1;
        check_output({tag, " done"}, 16'(frame_done), 16'(exp_done));
        check_output({tag, " result"}, 16'(result), 16'(model_result));
        vsync_neg = 1'b1;
        @(posedge clk);
        #1;
        check_output({tag, " pulse end"}, 16'(frame_done), 16'h0);
        check_output({tag, " hold"}, 16'(result), 16'(model_result));
    endtask

    initial begin
        int         w;
        int         sel;
        int         half;
        logic [7:0] pix;

        reset        = 1'b1;
        pixel_in     = 8'h00;
        vga_x        = 10'd0;
        vga_y        = 10'd0;
        vsync_neg    = 1'b1;
        pending_pix  = 8'h00;
        model_armed  = 1'b0;
        model_result = 9'h000;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check_output("reset result", 16'(result), 16'h0);
        check_output("reset done", 16'(frame_done), 16'h0);
        reset = 1'b0;

        for (int i = 0; i < 500; i++) apply_stimulus(i % 176, i / 176, 8'hE0);
        frame_boundary("partial frame");

        for (int i = 0; i < 2000; i++) apply_stimulus(i % 176, i / 176, 8'hE0);
        frame_boundary("red frame");
        check_output("red frame value", 16'(result), 16'h101);

        for (int i = 0; i < 1800; i++) begin
            pix = (i < 1000) ? 8'h03 : (i < 1500) ? 8'hE0 : 8'hFF;
            apply_stimulus(i % 176, i / 176, pix);
        end
        frame_boundary("blue majority");

        for (int i = 0; i < 399; i++) apply_stimulus(i % 176, 50 + i / 176, 8'hE0);
        frame_boundary("red 399");

        for (int i = 0; i < 1200; i++) apply_stimulus(i % 176, i / 176, (i % 2 == 0) ? 8'hE0 : 8'h03);
        frame_boundary("tie 600");

        for (int i = 0; i < 200; i++) apply_stimulus(176, $urandom_range(0, 143), 8'hE0);
        for (int i = 0; i < 200; i++) apply_stimulus($urandom_range(0, 175), 144, 8'hE0);
        frame_boundary("outside area");

        for (int i = 0; i < 399; i++) apply_stimulus($urandom_range(0, 174), $urandom_range(0, 142), 8'hE0);
        apply_stimulus(175, 143, 8'hE0);
        frame_boundary("corner 400");

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(i % 176, 100, 8'hE0);
            apply_stimulus(700, 700, 8'h00);
        end
        frame_boundary("alignment");

        for (int f = 0; f < 6; f++) begin
            w = $urandom_range(2, 6);
            for (int i = 0; i < 1200; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < w)
                    pix = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
                else if (sel < 8)
                    pix = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'($urandom_range(2, 3))};
                else
                    pix = 8'($urandom);
                apply_stimulus($urandom_range(0, 199), $urandom_range(0, 159), pix);
            end
            frame_boundary($sformatf("random %0d", f));
        end

        for (int i = 0; i < 5000; i++) apply_stimulus(i % 176, (i / 176) % 144, 8'hE0);
        #7 reset = 1'b1;
        #1;
        check_output("mid reset result", 16'(result), 16'h0);
        check_output("mid reset done", 16'(frame_done), 16'h0);
        model_armed  = 1'b0;
        model_result = 9'h000;
        model_clear();
        pending_pix  = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 500; i++) apply_stimulus(i % 176, i / 176, 8'h03);
        frame_boundary("after reset discard");
        for (int i = 0; i < 750; i++) apply_stimulus(i % 176, i / 176, (i < 300) ? 8'hE0 : 8'h03);
        frame_boundary("fresh counts");
        check_output("fresh counts value", 16'(result), 16'h102);

`ifdef SHAPE_DETECT_EN
        for (int y = 20; y <= 123; y++)
            for (int x = 40; x <= 135; x++) apply_stimulus(x, y, 8'hE0);
        frame_boundary("shape square");
        for (int y = 10; y <= 130; y++) begin
            half = (y - 10) / 2;
            for (int x = 88 - half; x <= 88 + half; x++) apply_stimulus(x, y, 8'hE0);
        end
        frame_boundary("shape triangle");
        check_output("triangle code", 16'(result[3:2]), 16'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
